r16_npipe_delay: RTL and testbench
==================================

// Module: r16_npipe_delay
// PURPOSE
//  Parametrised modulus (N) delay pipeline for the radix-16 FFT datapath: carries CH
//  channels of P_WIDTH-bit modulus through DEPTH register stages, aligned with the
//  butterfly pipeline. Adds per-stage valid tags, global stall, sync flush, and an
//  N_stable flag meaning every stage holds the same valid modulus (safe to start
//  modular arithmetic). Replaces fixed single-stage N pipe registers.
// PARAMETERS
//  P_WIDTH  64    bits per modulus channel
//  CH       1     number of independent modulus channels (lanes share valid/stall)
//  DEPTH    4     register stages, >=1; latency in enabled cycles
//  P_ZERO   {P_WIDTH{1'b0}}  reset/flush value of every data stage
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous reset, active-high
//  en         in   1            advance pipeline; 0 = hold all state
//  flush      in   1            sync clear of valids/stable logic (priority over en)
//  N_in       in   CH*P_WIDTH   modulus in, channel c at [c*P_WIDTH +: P_WIDTH]
//  N_vld_in   in   1            N_in valid
//  N_out      out  CH*P_WIDTH   stage DEPTH data
//  N_vld_out  out  1            stage DEPTH valid
//  N_stable   out  1            all DEPTH stages valid and equal (registered)
//  par_err    out  1            sticky parity error (only with R16_NPIPE_PARITY_EN)
// BEHAVIOUR
//  - Reset (rst=1, async): all data stages = P_ZERO, all valids 0, N_stable 0,
//    counter 0, last_vld 0, par_err 0. Outputs stay so until first en edge after release.
//  - Priority per edge: rst > flush > en > hold.
//  - en=1, flush=0: stage[0]<=N_in, vld[0]<=N_vld_in; stage[k]<=stage[k-1] for k>=1.
//    Data also shifts when valid=0 (no gating needed). Latency DEPTH en-cycles.
//  - en=0, flush=0: every register holds, including counter and N_stable.
//  - flush=1: all valids 0, last_vld 0, cnt 0, N_stable 0; data regs may hold.
//  - Stability tracker: regs last_N (CH*P_WIDTH), last_vld, cnt [$clog2(DEPTH):0].
//    On en edge: if !N_vld_in -> last_vld<=0; else if !last_vld or N_in!=last_N ->
//    last_N<=N_in, last_vld<=1, cnt<=DEPTH-1; else cnt<=cnt-1 if cnt!=0.
//    N_stable = registered (last_vld && cnt==0), updated with tracker (same edge).
//    DEPTH=1: N_stable rises on the same edge the first valid N is accepted.
//  - Any one-channel change or an invalid bubble drops N_stable on that edge.
//  - Compare is full CH*P_WIDTH wide; no arithmetic on data.
// CONFIGURATION
//  R16_NPIPE_PARITY_EN defined: each stage stores an even-parity bit per channel
//   computed at stage 0; at output, if N_vld_out and parity mismatch on any channel,
//   par_err sets and stays 1 until rst (flush does not clear). Port par_err present.
//  Undefined: no parity storage, par_err port absent; all other behaviour identical.
// TESTING
//  1 rst pulse mid-stream with valids in flight -> N_vld_out=0, N_out=0, N_stable=0
//    immediately (before next clk edge).
//  2 DEPTH=4, CH=2, en=1, N_vld_in=1, N_in={A,B} constant from cycle 0 -> N_vld_out
//    and N_out={A,B} after edge 3 (4th edge); N_stable=1 after edge 3.
//  3 Stable on {A,B}, then one cycle N_in={A,C} -> N_stable 0 on that edge, returns 1
//    exactly 3 en-edges later if {A,C} held; N_out shows {A,C} 4 edges after change.
//  4 en=0 for 5 cycles mid-fill -> N_out, N_vld_out, N_stable unchanged; resume adds
//    exactly 5 cycles to latency.
//  5 flush=1 with en=1 while stable -> next edge all valid 0, N_stable 0; refill
//    needs DEPTH edges again; flush with en=0 same result.
//  6 PARITY_EN: force-flip one bit in stage 2 via bench -> par_err=1 when word reaches
//    output, stays 1 through flush, clears only on rst.

Source files
------------

// File: rtl/r16_npipe_delay.sv
// ---------------------------------------------------------------------------
// r16_npipe_delay
//   Modulus (N) delay pipeline for the radix-16 FFT datapath. Carries CH lanes
//   of P_WIDTH-bit modulus through DEPTH register stages, with a per-stage valid
//   tag, a global stall (en=0 holds everything), a synchronous flush and an
//   N_stable flag that is high when every stage holds the same valid modulus.
//
// Optional feature macro: R16_NPIPE_PARITY_EN
//   When defined, every stage carries one even-parity bit per lane (computed at
//   stage 0) and a sticky par_err output flags a mismatch seen at the output.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous reset, active-high
//   en         in   1            advance pipeline; 0 holds all state
//   flush      in   1            synchronous clear of valids / stability (beats en)
//   N_in       in   CH*P_WIDTH   modulus in, lane c at [c*P_WIDTH +: P_WIDTH]
//   N_vld_in   in   1            N_in valid
//   N_out      out  CH*P_WIDTH   last-stage data
//   N_vld_out  out  1            last-stage valid
//   N_stable   out  1            all stages valid and equal (registered)
//   par_err    out  1            sticky parity error (parity build only)
// ---------------------------------------------------------------------------
module r16_npipe_delay #(
  parameter int unsigned        P_WIDTH = 64,
  parameter int unsigned        CH      = 1,
  parameter int unsigned        DEPTH   = 4,
  parameter logic [P_WIDTH-1:0] P_ZERO  = {P_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [CH*P_WIDTH-1:0] N_in,
  input  logic                  N_vld_in,
  output logic [CH*P_WIDTH-1:0] N_out,
  output logic                  N_vld_out,
  output logic                  N_stable
`ifdef R16_NPIPE_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  localparam int unsigned     W        = CH * P_WIDTH;
  localparam int unsigned     CW       = $clog2(DEPTH) + 1;
  localparam logic [W-1:0]    RST_WORD = {CH{P_ZERO}};
  localparam logic [CW-1:0]   CNT_LOAD = CW'(DEPTH - 1);

  // Pipeline stages
  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  // Stability tracker: last accepted modulus and countdown of equal repeats
  logic [W-1:0]     last_n_q, last_n_d;
  logic             last_vld_q, last_vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stable_q, stable_d;

`ifdef R16_NPIPE_PARITY_EN
  logic [CH-1:0]    par_q [DEPTH];
  logic [CH-1:0]    par_d [DEPTH];
  logic             par_err_q, par_err_d;

  // Even parity of each lane of a packed word
  function automatic logic [CH-1:0] chan_parity(input logic [W-1:0] word);
    logic [CH-1:0] p;
    p = '0;
    for (int c = 0; c < int'(CH); c++) begin
      p[c] = ^word[c*P_WIDTH +: P_WIDTH];
    end
    return p;
  endfunction
`endif

  // Next-state logic: flush beats en; en=0 holds every register
  always_comb begin
    data_d     = data_q;
    vld_d      = vld_q;
    last_n_d   = last_n_q;
    last_vld_d = last_vld_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
`ifdef R16_NPIPE_PARITY_EN
    par_d      = par_q;
    // Checked every cycle on the held output word; sticky until reset
    par_err_d  = par_err_q |
                 (vld_q[DEPTH-1] && (par_q[DEPTH-1] != chan_parity(data_q[DEPTH-1])));
`endif
    if (flush) begin
      // Data stages are left as they are; only the tags and tracker clear
      vld_d      = '0;
      last_vld_d = 1'b0;
      cnt_d      = '0;
      stable_d   = 1'b0;
    end else if (en) begin
      data_d[0] = N_in;
      vld_d[0]  = N_vld_in;
      for (int k = 1; k < int'(DEPTH); k++) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
`ifdef R16_NPIPE_PARITY_EN
      par_d[0] = chan_parity(N_in);
      for (int k = 1; k < int'(DEPTH); k++) begin
        par_d[k] = par_q[k-1];
      end
`endif
      // A bubble or any lane change restarts the DEPTH-long run of equal values
      if (!N_vld_in) begin
        last_vld_d = 1'b0;
      end else if (!last_vld_q || (N_in != last_n_q)) begin
        last_n_d   = N_in;
        last_vld_d = 1'b1;
        cnt_d      = CNT_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      // Uses the post-update tracker so DEPTH=1 is stable on the accepting edge
      stable_d = last_vld_d && (cnt_d == '0);
    end else begin
      stable_d = stable_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= RST_WORD;
      end
      vld_q      <= '0;
      last_n_q   <= '0;
      last_vld_q <= 1'b0;
      cnt_q      <= '0;
      stable_q   <= 1'b0;
`ifdef R16_NPIPE_PARITY_EN
      for (int k = 0; k < int'(DEPTH); k++) begin
        par_q[k] <= chan_parity(RST_WORD);
      end
      par_err_q  <= 1'b0;
`endif
    end else begin
      data_q     <= data_d;
      vld_q      <= vld_d;
      last_n_q   <= last_n_d;
      last_vld_q <= last_vld_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
`ifdef R16_NPIPE_PARITY_EN
      par_q      <= par_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign N_out     = data_q[DEPTH-1];
  assign N_vld_out = vld_q[DEPTH-1];
  assign N_stable  = stable_q;
`ifdef R16_NPIPE_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_r16_npipe_delay.sv
// ---------------------------------------------------------------------------
// tb_r16_npipe_delay
//   Scoreboard bench for r16_npipe_delay (DEPTH=4, CH=2, P_WIDTH=16).
//   The driver keeps a history of accepted inputs: every valid word accepted
//   on an advancing edge is expected at the output DEPTH-1 advancing edges
//   later, and N_stable is expected whenever the last DEPTH accepted inputs
//   since reset/flush are all valid and identical. A monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_r16_npipe_delay;

  localparam int P_WIDTH = 16;
  localparam int CH      = 2;
  localparam int DEPTH   = 4;
  localparam int W       = CH * P_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] N_in = '0;
  logic         N_vld_in = 1'b0;
  logic [W-1:0] N_out;
  logic         N_vld_out;
  logic         N_stable;
`ifdef R16_NPIPE_PARITY_EN
  logic         par_err;
`endif

  r16_npipe_delay #(
    .P_WIDTH(P_WIDTH),
    .CH     (CH),
    .DEPTH  (DEPTH),
    .P_ZERO ({P_WIDTH{1'b0}})
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .N_in     (N_in),
    .N_vld_in (N_vld_in),
    .N_out    (N_out),
    .N_vld_out(N_vld_out),
    .N_stable (N_stable)
`ifdef R16_NPIPE_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
  } hist_t;

  exp_t  exp_q[$];
  hist_t hist[$];
  logic  exp_stable = 1'b0;
  int    idx = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Monitor edge bookkeeping
  logic  adv = 1'b0;
  int    edge_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic model_stable();
    int n;
    n = hist.size();
    if (n < DEPTH) return 1'b0;
    for (int i = n - DEPTH; i < n; i++) begin
      if (!hist[i].v) return 1'b0;
      if (hist[i].d != hist[n-1].d) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] word(input int a, input int b);
    logic [P_WIDTH-1:0] ha, hb;
    ha = P_WIDTH'(16'h00A5 + a * 16'h1111);
    hb = P_WIDTH'(16'h5A00 + b * 16'h0101);
    return {hb, ha};
  endfunction

  // One clock edge with the given inputs; model updated after the edge
  task automatic step(input logic e, input logic f, input logic v, input logic [W-1:0] d);
    en = e; flush = f; N_vld_in = v; N_in = d;
    @(posedge clk);
    if (f) begin
      hist.delete();
      exp_q.delete();
    end else if (e) begin
      idx++;
      hist.push_back('{v: v, d: d});
      while (hist.size() > DEPTH) void'(hist.pop_front());
      if (v) exp_q.push_back('{data: d, due: idx + DEPTH - 1});
    end
    exp_stable = model_stable();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hist.delete();
    exp_q.delete();
    exp_stable = 1'b0;
    #2;
    check("rst_vld_out", W'(N_vld_out), W'(0));
    check("rst_out", N_out, W'(0));
    check("rst_stable", W'(N_stable), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Advancing-edge counter seen by the monitor
  always @(posedge clk) begin
    if (!rst && en && !flush) begin
      adv      <= 1'b1;
      edge_cnt <= edge_cnt + 1;
    end else begin
      adv <= 1'b0;
    end
  end

  // Monitor: compare stability every cycle, pop on each newly presented word
  always @(negedge clk) begin
    if (!rst) begin
      check("stable", W'(N_stable), W'(exp_stable));
      if (adv && N_vld_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", W'(N_vld_out), W'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data", N_out, e.data);
          check("latency", W'(edge_cnt), W'(e.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= edge_cnt) begin
        check("missing_out", W'(N_vld_out), W'(1));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] ab, ac, rw;
    ab = word(1, 2);
    ac = word(1, 3);

    // Reset state
    do_reset();

    // Constant stream, then one-lane change, then hold
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, ab);
    check("stable_ab", W'(N_stable), W'(1));
    step(1'b1, 1'b0, 1'b1, ac);
    check("stable_drop", W'(N_stable), W'(0));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, ac);

    // Stall mid-fill
    step(1'b1, 1'b0, 1'b1, ab);
    step(1'b1, 1'b0, 1'b1, ab);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, ac);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, ab);

    // Flush with en=1 while stable, refill, flush with en=0
    step(1'b1, 1'b1, 1'b1, ab);
    check("flush_vld", W'(N_vld_out), W'(0));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, ab);
    step(1'b0, 1'b1, 1'b1, ab);
    check("flush_en0_stable", W'(N_stable), W'(0));

    // Randomized phase with a reset mid-stream
    for (int i = 0; i < 400; i++) begin
      rw = word(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      if (i == 200) begin
        step(1'b1, 1'b0, 1'b1, rw);
        do_reset();
      end else begin
        step(($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
             (($urandom_range(0, 99) < 70) && (hist.size() != 0)) ? hist[hist.size()-1].d : rw);
      end
    end

    // Drain
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, 1'b0, '0);
    check("drain_empty", W'(exp_q.size()), W'(0));
`ifdef R16_NPIPE_PARITY_EN
    check("par_err_clean", W'(par_err), W'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
